// File: rtl/shr_pkg.sv
// ---------------------------------------------------------------------------
// shr_pkg
// Shared types and helpers for the sequential right shifter (shr_seq_unit).
//   state_t    : controller states (IDLE, SHIFT, DONE)
//   shift_op_t : operation encoding carried on the 'arith' input
//   DEF_WIDTH / DEF_SHW : default operand width and derived shift-amount width
//   shr_fill_bit() : bit shifted into vacated MSBs for a given op and operand
// ---------------------------------------------------------------------------
package shr_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OP_SRL = 1'b0,
        OP_SRA = 1'b1
    } shift_op_t;

    // SRA replicates the operand sign bit, SRL always fills with zero.
    function automatic logic shr_fill_bit(input logic arith, input logic msb);
        logic fill_s;
        if (shift_op_t'(arith) == OP_SRA) begin
            fill_s = msb;
        end else begin
            fill_s = 1'b0;
        end
        return fill_s;
    endfunction

endpackage : shr_pkg

// File: rtl/shr_stage.sv
// ---------------------------------------------------------------------------
// shr_stage
// Combinational conditional right shift by a fixed distance DIST.
// Ports:
//   in   [WIDTH-1:0] : operand
//   en               : 1 = shift by DIST, 0 = pass operand through unchanged
//   fill             : value placed in the DIST vacated MSBs
//   out  [WIDTH-1:0] : result
// DIST must lie in 1..WIDTH-1.
// ---------------------------------------------------------------------------
module shr_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] shifted_s;

    // Fixed-distance shift: replicate the fill bit above the surviving bits.
    always_comb begin
        shifted_s = {{DIST{fill}}, in[WIDTH-1:DIST]};
    end

    // Apply the stage only when its amount bit is set.
    always_comb begin
        if (en) begin
            out = shifted_s;
        end else begin
            out = in;
        end
    end

endmodule : shr_stage

// File: rtl/shr_seq_unit.sv
// ---------------------------------------------------------------------------
// shr_seq_unit
// Multi-cycle SRL/SRA shifter. One binary-weighted stage (WIDTH/2, ..., 2, 1)
// is applied per clock, so latency does not depend on the shift amount.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : request handshake (data_in, shamt, arith)
//   data_in  [WIDTH-1:0]  : operand
//   shamt    [SHW-1:0]    : shift amount 0..WIDTH-1
//   arith                 : 1 = SRA, 0 = SRL
//   out_valid / out_ready : result handshake
//   data_out [WIDTH-1:0]  : registered result; qualify with out_valid
// Timing: request accepted on edge N -> out_valid rises on edge N+SHW+1 and
// stays high (data_out stable) until out_ready is sampled high.
// ---------------------------------------------------------------------------
module shr_seq_unit
    import shr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out
);

    // Step counter must hold 0..SHW-1.
    localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;

    state_t           state_r;
    logic [STW-1:0]   step_r;
    logic [SHW-1:0]   amt_r;
    logic             fill_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] data_out_r;
    logic             out_valid_r;
    logic             in_ready_r;

    logic [WIDTH-1:0] stage_out_s [SHW];
    logic [WIDTH-1:0] next_work_s;

    // Stage k shifts by 2^(SHW-1-k), gated by the matching amount bit.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shr_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << (SHW - 1 - k))
        ) u_stage (
            .in   (work_r),
            .en   (amt_r[SHW-1-k]),
            .fill (fill_r),
            .out  (stage_out_s[k])
        );
    end

    // Select the stage output addressed by the current step.
    always_comb begin
        next_work_s = work_r;
        for (int k = 0; k < SHW; k++) begin
            next_work_s = (step_r == STW'(k)) ? stage_out_s[k] : next_work_s;
        end
    end

    // Controller: accept, walk the stages, then present and hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            step_r      <= '0;
            amt_r       <= '0;
            fill_r      <= 1'b0;
            work_r      <= '0;
            data_out_r  <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        work_r     <= data_in;
                        amt_r      <= shamt;
                        fill_r     <= shr_fill_bit(arith, data_in[WIDTH-1]);
                        step_r     <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_r <= next_work_s;
                    step_r <= step_r + STW'(1);
                    if (step_r == STW'(SHW - 1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; out_ready is
                    // only honoured once out_valid is actually visible.
                    if (!out_valid_r) begin
                        data_out_r  <= work_r;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;

endmodule : shr_seq_unit

// File: tb/tb_shr_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_shr_seq_unit
// Directed and randomised checks of shr_seq_unit (WIDTH = 32).
// ---------------------------------------------------------------------------
module tb_shr_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;

    int checks = 0;
    int passed = 0;

    shr_seq_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait for out_valid; does not complete the handshake.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          output logic [31:0] res, output int lat);
        int w;
        w = 0;
        data_in  = d;
        shamt    = s;
        arith    = a;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = ~d;
        shamt    = ~s;
        arith    = ~a;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = data_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        data_in = 32'h0; shamt = 5'd0; arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b required=0", out_valid);
        else passed++;
        checks++;
        if (data_out !== 32'h0) $display("FAIL reset_data_out got=%h required=00000000", data_out);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_srl_latency();
        logic [31:0] r; int lat;
        out_ready = 1'b1;
        run_op(32'h8000_0000, 5'd31, 1'b0, r, lat);
        checks++;
        if (r !== 32'h0000_0001) $display("FAIL srl31 got=%h required=00000001", r);
        else passed++;
        checks++;
        if (lat !== 6) $display("FAIL srl31_latency got=%0d required=6", lat);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL srl31_return in_ready=%b out_valid=%b required=1/0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_sra();
        logic [31:0] r; int lat;
        out_ready = 1'b1;
        run_op(32'h8000_0000, 5'd4, 1'b1, r, lat);
        checks++;
        if (r !== 32'hF800_0000) $display("FAIL sra_neg got=%h required=f8000000", r);
        else passed++;
        @(posedge clk); #1;
        run_op(32'h7FFF_FFF0, 5'd4, 1'b1, r, lat);
        checks++;
        if (r !== 32'h07FF_FFFF) $display("FAIL sra_pos got=%h required=07ffffff", r);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_shift();
        logic [31:0] r; int lat;
        out_ready = 1'b1;
        for (int op = 0; op < 2; op++) begin
            run_op(32'hDEAD_BEEF, 5'd0, op[0], r, lat);
            checks++;
            if (r !== 32'hDEAD_BEEF) $display("FAIL zero_shift op=%0d got=%h required=deadbeef", op, r);
            else passed++;
            checks++;
            if (lat !== 6) $display("FAIL zero_shift_latency op=%0d got=%0d required=6", op, lat);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; int lat;
        out_ready = 1'b0;
        run_op(32'h0000_F000, 5'd8, 1'b0, r, lat);
        checks++;
        if (r !== 32'h0000_00F0) $display("FAIL bp_result got=%h required=000000f0", r);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            in_valid = (c == 1);
            data_in  = 32'hFFFF_FFFF;
            shamt    = 5'd1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || data_out !== 32'h0000_00F0 || in_ready !== 1'b0)
                $display("FAIL bp_hold cyc=%0d out_valid=%b data_out=%h in_ready=%b required=1/000000f0/0",
                         c, out_valid, data_out, in_ready);
            else passed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release out_valid=%b in_ready=%b required=0/1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat;
        out_ready = 1'b1;
        data_in = 32'hAAAA_5555; shamt = 5'd3; arith = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;             // accept edge
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;             // now in the third SHIFT cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL mid_reset out_valid=%b data_out=%h in_ready=%b required=0/00000000/1",
                     out_valid, data_out, in_ready);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h1234_5678, 5'd12, 1'b0, r, lat);
        checks++;
        if (r !== 32'h0001_2345) $display("FAIL post_reset_srl got=%h required=00012345", r);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, d, exp; logic [4:0] s; logic a; int lat, stall, seen;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            exp = a ? 32'($signed(d) >>> s) : (d >> s);
            out_ready = 1'b0;
            run_op(d, s, a, r, lat);
            if (out_valid === 1'b1) seen++;
            checks++;
            if (r !== exp) $display("FAIL rand_%0d d=%h s=%0d a=%b got=%h required=%h", i, d, s, a, r, exp);
            else passed++;
            stall = $urandom_range(0, 3);
            repeat (stall) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL rand_dup_%0d out_valid=%b required=0", i, out_valid);
            else passed++;
        end
        checks++;
        if (seen !== 1000) $display("FAIL rand_count got=%0d required=1000", seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_srl_latency();
        test_sra();
        test_zero_shift();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_shr_seq_unit
